sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 24, giving the SDRAM logical word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the SDRAM data width.
REQ-003 The block SHALL have parameter WDOG_CYCLES, default 64, giving the maximum cycles a granted access waits for sd_ack.
REQ-004 The block SHALL have parameter MAX_INHIBIT, default 2^20, giving the maximum continuous cycles of refresh inhibit.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- spi_critical  in  1  timing-critical SPI window is active.
- spi_req  in  1  SPI read request; held until spi_ack.
- spi_addr  in  ADDR_WIDTH-1  SPI byte address.
- spi_ack  out  1  one-cycle pulse: spi_data is valid.
- spi_data  out  8  read byte.
- user_req  in  1  user request; held until user_ack.
- user_we  in  1  1 = write, 0 = read; sampled at grant.
- user_addr  in  ADDR_WIDTH  user word address.
- user_wr_data  in  DATA_WIDTH  write data.
- user_ack  out  1  one-cycle completion pulse.
- user_rd_data  out  DATA_WIDTH  read word.
- user_idle  out  1  arbiter is IDLE, spi_critical is low, and sd_idle is high.
- sd_enable  out  1  SDRAM access request, level.
- sd_we  out  1  SDRAM write.
- sd_addr  out  ADDR_WIDTH  SDRAM address.
- sd_wr_data  out  DATA_WIDTH  SDRAM write data.
- sd_rd_data  in  DATA_WIDTH  SDRAM read data.
- sd_ack  in  1  SDRAM access complete.
- sd_idle  in  1  controller idle.
- sd_refresh_inhibit  out  1  suppress SDRAM refresh.
- err_timeout  out  1  sticky: the watchdog has fired.
- err_inhibit  out  1  sticky: the inhibit limit has been exceeded.

Function
REQ-006 The block SHALL implement the states IDLE, SPI_BUSY and USER_BUSY, with registered state.
REQ-007 In IDLE, if spi_req=1, the block SHALL move to SPI_BUSY next cycle; otherwise, if user_req=1 and spi_critical=0, it SHALL move to USER_BUSY; otherwise it SHALL stay in IDLE.
REQ-008 SPI SHALL have fixed priority, and a granted access SHALL never be preempted.
REQ-009 While spi_critical=1, user requests SHALL NOT be granted; a USER_BUSY access already in flight SHALL complete normally.
REQ-010 At grant, sd_addr, sd_we and sd_wr_data SHALL be latched and held constant until the access ends.
- SPI grant: sd_addr={spi_addr[ADDR_WIDTH-2:0],1'b0}, sd_we=0, sd_wr_data=0.
- User grant: user_addr, user_we and user_wr_data are copied directly.
REQ-011 sd_enable SHALL be 1 exactly while in SPI_BUSY or USER_BUSY; it is asserted the cycle after the request is seen in IDLE.
REQ-012 When sd_ack=1 in a busy state, the block SHALL do all of the following on the next edge:
- return to IDLE with sd_enable=0;
- pulse the owner's ack for one cycle;
- register read data: spi_data=sd_rd_data[7:0], user_rd_data=sd_rd_data.
REQ-013 An sd_ack received in IDLE SHALL be ignored.
REQ-014 A request still high in the cycle after its ack SHALL be treated as a new request; the minimum request-to-request spacing is 2 cycles.
REQ-015 A per-access watchdog SHALL count busy cycles; if it reaches WDOG_CYCLES without sd_ack, the block SHALL:
- return to IDLE;
- pulse the owner's ack with data 0;
- set err_timeout.
REQ-016 sd_refresh_inhibit SHALL equal spi_critical registered once, forced to 0 while the inhibit counter has saturated.
REQ-017 The inhibit counter SHALL increment each cycle that spi_critical=1, clear when spi_critical=0, and saturate at MAX_INHIBIT; on reaching MAX_INHIBIT it SHALL set err_inhibit.
REQ-018 If spi_req and user_req rise in the same IDLE cycle, SPI SHALL be served first, and user SHALL be served in the IDLE cycle after spi_ack if spi_critical=0.
REQ-019 Both error flags SHALL be cleared only by reset.

Reset
REQ-020 While reset_n=0, the block SHALL asynchronously force:
- state=IDLE;
- every output, including sticky flags, and all counters to 0;
- user_idle=0.
This SHALL take effect immediately, including mid-access.
REQ-021 After reset_n rises, the block SHALL accept requests on the first clock edge; the requester is responsible for re-issuing any access aborted by reset.

Verification
REQ-022 Single SPI read: spi_addr=0x000010, sd_ack 5 cycles after sd_enable, sd_rd_data=0xBEEF -> sd_addr=0x000020, sd_we=0, one spi_ack with spi_data=0xEF.
REQ-023 User write: user_addr=0x001234, user_wr_data=0xA5A5, user_we=1, spi_critical=0 -> sd_we=1, sd_addr=0x001234, one user_ack, no spi_ack.
REQ-024 Simultaneous spi_req and user_req, spi_critical=0 -> spi_ack precedes user_ack; sd_enable drops for exactly 1 cycle between the two accesses.
REQ-025 spi_critical=1 with user_req held for 100 cycles -> no user grant; user_idle=0; sd_refresh_inhibit=1 from the 2nd cycle; after spi_critical falls, user_ack follows.
REQ-026 sd_ack withheld with WDOG_CYCLES=8 -> after 8 busy cycles, sd_enable=0, ack pulse with data 0, err_timeout=1 and still 1 after 10 further idle cycles.
REQ-027 reset_n pulsed low during USER_BUSY -> sd_enable=0 and state IDLE without waiting for a clock edge; no user_ack is produced; err flags=0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//
// Shares one SDRAM controller port between a timing-critical SPI read path
// and a general user read/write path. SPI always wins at arbitration. An
// access that has been granted is never preempted. A per-access watchdog
// ends any access the controller never acknowledges. A separate counter
// limits how long the SPI side may keep refresh suppressed.
//
// Ports
//   clk, reset_n        system clock (rising edge) / async active-low reset
//   spi_critical        SPI timing window active: blocks user grants and
//                       requests refresh inhibit
//   spi_req/spi_addr    SPI byte-address read request, held until spi_ack
//   spi_ack/spi_data    one-cycle completion pulse with the read byte
//   user_req/user_we    user request (held until user_ack) and direction
//   user_addr           user word address
//   user_wr_data        user write data
//   user_ack            one-cycle completion pulse
//   user_rd_data        user read word
//   user_idle           arbiter idle, no SPI window, controller idle
//   sd_enable/sd_we     SDRAM access request (level) and direction
//   sd_addr/sd_wr_data  SDRAM address and write data, stable for the access
//   sd_rd_data/sd_ack   SDRAM read data and completion strobe
//   sd_idle             controller reports idle
//   sd_refresh_inhibit  suppress SDRAM refresh
//   err_timeout         sticky: an access was ended by the watchdog
//   err_inhibit         sticky: refresh inhibit hit its length limit
module sdram_arbiter #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int WDOG_CYCLES = 64,
  parameter int MAX_INHIBIT = 1 << 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_critical,
  input  logic                  spi_req,
  input  logic [ADDR_WIDTH-2:0] spi_addr,
  output logic                  spi_ack,
  output logic [7:0]            spi_data,
  input  logic                  user_req,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wr_data,
  output logic                  user_ack,
  output logic [DATA_WIDTH-1:0] user_rd_data,
  output logic                  user_idle,
  output logic                  sd_enable,
  output logic                  sd_we,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  input  logic                  sd_ack,
  input  logic                  sd_idle,
  output logic                  sd_refresh_inhibit,
  output logic                  err_timeout,
  output logic                  err_inhibit
);

  typedef enum logic [1:0] {
    IDLE,
    SPI_BUSY,
    USER_BUSY
  } state_t;

  // Watchdog only needs to count up to WDOG_CYCLES-1; the inhibit counter
  // must be able to hold MAX_INHIBIT itself, which marks saturation.
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int INH_W  = $clog2(MAX_INHIBIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [INH_W-1:0]  INH_MAX   = INH_W'(MAX_INHIBIT);
  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(MAX_INHIBIT - 1);

  state_t            state;
  logic [WDOG_W-1:0] wdog;
  logic [INH_W-1:0]  inh_cnt;
  logic              crit_q;
  logic              running;

  // Arbitration FSM. While an ack is being pulsed, the same requester's
  // req is still the old request (it only sees the ack now), so it is
  // masked; the other requester can be granted in that cycle, leaving a
  // single idle cycle between back-to-back accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wdog         <= '0;
      running      <= 1'b0;
      sd_enable    <= 1'b0;
      sd_we        <= 1'b0;
      sd_addr      <= '0;
      sd_wr_data   <= '0;
      spi_ack      <= 1'b0;
      spi_data     <= '0;
      user_ack     <= 1'b0;
      user_rd_data <= '0;
      err_timeout  <= 1'b0;
    end else begin
      running  <= 1'b1;
      spi_ack  <= 1'b0;
      user_ack <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (spi_req && !spi_ack) begin
            state      <= SPI_BUSY;
            sd_enable  <= 1'b1;
            sd_we      <= 1'b0;
            sd_addr    <= {spi_addr, 1'b0};
            sd_wr_data <= '0;
          end else if (user_req && !user_ack && !spi_critical) begin
            state      <= USER_BUSY;
            sd_enable  <= 1'b1;
            sd_we      <= user_we;
            sd_addr    <= user_addr;
            sd_wr_data <= user_wr_data;
          end
        end
        SPI_BUSY, USER_BUSY: begin
          // A real ack on the last watchdog cycle still counts as success.
          if (sd_ack || wdog == WDOG_LAST) begin
            state     <= IDLE;
            sd_enable <= 1'b0;
            if (!sd_ack) begin
              err_timeout <= 1'b1;
            end
            if (state == SPI_BUSY) begin
              spi_ack  <= 1'b1;
              spi_data <= sd_ack ? sd_rd_data[7:0] : 8'h00;
            end else begin
              user_ack     <= 1'b1;
              user_rd_data <= sd_ack ? sd_rd_data : '0;
            end
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sd_enable <= 1'b0;
        end
      endcase
    end
  end

  // Refresh inhibit: spi_critical delayed one cycle, with a run-length
  // counter that saturates and then forces inhibit off until the SPI
  // window closes and clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inh_cnt     <= '0;
      crit_q      <= 1'b0;
      err_inhibit <= 1'b0;
    end else begin
      crit_q <= spi_critical;
      if (spi_critical) begin
        if (inh_cnt != INH_MAX) begin
          inh_cnt <= inh_cnt + INH_W'(1);
        end
        if (inh_cnt == INH_LAST) begin
          err_inhibit <= 1'b1;
        end
      end else begin
        inh_cnt <= '0;
      end
    end
  end

  assign sd_refresh_inhibit = crit_q && (inh_cnt != INH_MAX);

  // running keeps user_idle low while reset is held even though the state
  // register reads IDLE during reset.
  assign user_idle = running && (state == IDLE) && !spi_critical && sd_idle;

endmodule
